// File: rtl/adder_tree_pipe_if.sv
// Beat-in / result-out bundle for the pipelined reduction tree.
// No storage of its own; the pipeline register latency lives in the tree.
// Valid/ready in both directions: in_ready is the tree's pipeline advance, out_ready is the sink's.
interface adder_tree_pipe_if #(
    parameter int ACC_BW = 32,
    parameter int NUM_IN = 64
);
    logic                           in_valid;
    logic                           in_ready;
    logic [NUM_IN-1:0][ACC_BW-1:0]  in_data;
    logic                           in_mode;
    logic                           out_valid;
    logic                           out_ready;
    logic [ACC_BW-1:0]              out_data;
    logic                           out_sat;

    // Producer/consumer side: drives operands and accepts results.
    modport master (
        output in_valid,
        output in_data,
        output in_mode,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_sat
    );

    // Tree side.
    modport slave (
        input  in_valid,
        input  in_data,
        input  in_mode,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_sat
    );
endinterface

// File: rtl/adder_tree_pipe.sv
// Radix-RADIX pipelined reduction of RADIX**LEVELS operands into a rounded mean or a saturated sum.
// LEVELS cycles from accept to out_valid; one beat per cycle.
// Global stall: when out_valid is held without out_ready, every stage freezes and in_ready drops.
module adder_tree_pipe #(
    parameter int ACC_BW = 32,
    parameter int RADIX  = 4,
    parameter int LEVELS = 3,
    parameter int SIGNED = 0
) (
    input  logic              clk,
    input  logic              rst,
    adder_tree_pipe_if.slave  bus
);
    // Bits of growth per level, total growth and full-sum width.
    localparam int LR     = (RADIX == 4) ? 2 : 1;
    localparam int S      = LEVELS * LR;
    localparam int NUM_IN = RADIX ** LEVELS;
    localparam int WF     = ACC_BW + S;

    // Rounding offset for the mean: half of one output LSB.
    localparam logic [WF-1:0] HALF = WF'(1) << (S - 1);

    logic              en;
    logic              out_vld;
    logic              full_mode;
    logic [WF-1:0]     full_sum;
    logic [ACC_BW-1:0] res_dat;
    logic              res_sat;
    logic [S:0]        top_bits;

    // The whole pipe advances together whenever the output slot is free or being drained.
    assign en           = ~out_vld | bus.out_ready;
    assign bus.in_ready = en & ~rst;

    for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
        // Level k has NK nodes, each WK bits wide; it reads NK*RADIX values of WP bits.
        localparam int NK = RADIX ** (LEVELS - k);
        localparam int WK = ACC_BW + k * LR;
        localparam int WP = WK - LR;

        logic [NK*RADIX-1:0][WP-1:0] src;
        logic                        src_vld;
        logic                        src_mode;
        logic [NK-1:0][WK-1:0]       sum_d;
        logic [NK-1:0][WK-1:0]       sum_q;
        logic                        vld_d;
        logic                        vld_q;
        logic                        mode_d;
        logic                        mode_q;

        if (k == 1) begin : g_src
            assign src      = bus.in_data;
            assign src_vld  = bus.in_valid;
            assign src_mode = bus.in_mode;
        end else begin : g_src
            assign src      = g_lvl[k-1].sum_q;
            assign src_vld  = g_lvl[k-1].vld_q;
            assign src_mode = g_lvl[k-1].mode_q;
        end

        // Node adders: extend each child by LR bits so the node sum is exact, then load on advance.
        always_comb begin
            sum_d  = sum_q;
            vld_d  = vld_q;
            mode_d = mode_q;
            if (en) begin
                vld_d  = src_vld;
                mode_d = src_mode;
                for (int j = 0; j < NK; j++) begin
                    sum_d[j] = '0;
                    for (int r = 0; r < RADIX; r++) begin
                        sum_d[j] = sum_d[j]
                                 + {{LR{(SIGNED != 0) && src[j*RADIX+r][WP-1]}},
                                    src[j*RADIX+r]};
                    end
                end
            end
        end

        // Stage register; a reset flushes every in-flight beat.
        always_ff @(posedge clk) begin
            if (rst) begin
                sum_q  <= '0;
                vld_q  <= 1'b0;
                mode_q <= 1'b0;
            end else begin
                sum_q  <= sum_d;
                vld_q  <= vld_d;
                mode_q <= mode_d;
            end
        end
    end

    assign full_sum  = g_lvl[LEVELS].sum_q;
    assign out_vld   = g_lvl[LEVELS].vld_q;
    assign full_mode = g_lvl[LEVELS].mode_q;

    // Mean: add half an LSB and keep the upper ACC_BW bits (floor, so ties go toward +inf).
    // Sum: clip to the ACC_BW range; the signed sum fits only if the top S+1 bits agree.
    always_comb begin
        res_dat  = '0;
        res_sat  = 1'b0;
        top_bits = full_sum[WF-1:ACC_BW-1];
        if (!full_mode) begin
            res_dat = ACC_BW'((full_sum + HALF) >> S);
        end else if (SIGNED != 0) begin
            if ((&top_bits) || !(|top_bits)) begin
                res_dat = full_sum[ACC_BW-1:0];
            end else begin
                res_sat = 1'b1;
                res_dat = full_sum[WF-1] ? {1'b1, {(ACC_BW-1){1'b0}}}
                                         : {1'b0, {(ACC_BW-1){1'b1}}};
            end
        end else begin
            if (|full_sum[WF-1:ACC_BW]) begin
                res_sat = 1'b1;
                res_dat = '1;
            end else begin
                res_dat = full_sum[ACC_BW-1:0];
            end
        end
    end

    assign bus.out_valid = out_vld;
    assign bus.out_data  = res_dat;
    assign bus.out_sat   = res_sat;

endmodule
